// File: rtl/axis_gate_fifo.sv
// AXI-Stream FIFO of 2^DEPTH_LOG2 beats whose output side is gated by an enable,
// either per beat or only at packet (tlast) boundaries, with occupancy and flush.
module axis_gate_fifo #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH_LOG2  = 2,
   parameter bit PACKET_MODE = 1'b1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  enable,
   input  logic                  flush,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  gated
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {
      CLOSED = 2'd0,
      OPEN   = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t                state;
   logic [DEPTH_LOG2:0]   w_ptr;
   logic [DEPTH_LOG2:0]   r_ptr;
   logic [DEPTH_LOG2:0]   w_ptr_nxt;
   logic [DEPTH_LOG2:0]   r_ptr_nxt;
   logic                  in_pkt;
   logic [DATA_WIDTH:0]   mem [DEPTH];
   logic                  empty;
   logic                  full;
   logic                  s_hs;
   logic                  m_hs;
   logic                  flush_now;
   logic                  push;

   assign empty = (w_ptr == r_ptr);
   assign full  = (w_ptr[DEPTH_LOG2] != r_ptr[DEPTH_LOG2]) &&
                  (w_ptr[DEPTH_LOG2-1:0] == r_ptr[DEPTH_LOG2-1:0]);

   // Ready depends only on registered pointers, so m_axis_tready never reaches it.
   assign s_axis_tready = aresetn && !full;
   assign m_axis_tvalid = (state != CLOSED) && !empty;
   assign {m_axis_tlast, m_axis_tdata} = mem[r_ptr[DEPTH_LOG2-1:0]];

   assign s_hs      = s_axis_tvalid && s_axis_tready;
   assign m_hs      = m_axis_tvalid && m_axis_tready;
   assign flush_now = flush && (state == CLOSED);
   assign push      = s_hs && !flush_now;

   // NOTE: every signal driven from always_comb gets a default first so no latch is inferred.
   always_comb begin
      w_ptr_nxt = w_ptr + {{DEPTH_LOG2{1'b0}}, push};
      r_ptr_nxt = r_ptr + {{DEPTH_LOG2{1'b0}}, m_hs};
      if (flush_now) begin
         r_ptr_nxt = w_ptr;
      end
   end

   // NOTE: storage carries no reset; the pointers alone define which entries are valid.
   always_ff @(posedge aclk) begin
      if (push) begin
         mem[w_ptr[DEPTH_LOG2-1:0]] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_ptr  <= '0;
         r_ptr  <= '0;
         count  <= '0;
         in_pkt <= 1'b0;
         state  <= CLOSED;
         gated  <= 1'b1;
      end else begin
         w_ptr <= w_ptr_nxt;
         r_ptr <= r_ptr_nxt;
         count <= w_ptr_nxt - r_ptr_nxt;

         if (flush_now) begin
            in_pkt <= 1'b0;
         end else if (m_hs) begin
            in_pkt <= !m_axis_tlast;
         end

         case (state)
            CLOSED: begin
               if (enable) begin
                  state <= OPEN;
                  gated <= 1'b0;
               end
            end
            OPEN: begin
               if (!enable) begin
                  if (!PACKET_MODE) begin
                     // A presented beat must complete its handshake before the gate shuts.
                     if (!m_axis_tvalid || m_hs) begin
                        state <= CLOSED;
                        gated <= 1'b1;
                     end
                  end else if ((!in_pkt && !m_axis_tvalid) || (m_hs && m_axis_tlast)) begin
                     state <= CLOSED;
                     gated <= 1'b1;
                  end else begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (m_hs && m_axis_tlast) begin
                  state <= CLOSED;
                  gated <= 1'b1;
               end else if (enable) begin
                  state <= OPEN;
               end
            end
            default: begin
               state <= CLOSED;
               gated <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/axis_gate_fifo.md
Name: axis_gate_fifo

Overview:
- Parametrised successor to the two-entry AXI-Stream gating buffer.
- Buffers a stream in a 2^DEPTH_LOG2-entry FIFO and gates the output side with an enable input.
- Gates either per beat or only at packet (tlast) boundaries.
- Adds occupancy reporting, a gate-status flag and a flush control. Sits inline in pipeline datapaths wherever a stage must be paused without violating AXI-Stream rules.

Parameters:
- DATA_WIDTH, 32, tdata width in bits (>=1).
- DEPTH_LOG2, 2, log2 of FIFO depth; depth D = 2^DEPTH_LOG2 (DEPTH_LOG2 >= 1).
- PACKET_MODE, 1, 1 = gate opens/closes only between packets; 0 = gate closes after any beat.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  asynchronous active-low reset.
- enable  in  1  gate request: 1 = pass data, 0 = stop output.
- flush  in  1  synchronous FIFO clear; honoured only while the gate is CLOSED.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of packet.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of packet.
- count  out  DEPTH_LOG2+1  number of stored beats, 0..D.
- gated  out  1  1 when the gate FSM is CLOSED.

Behaviour:
- Reset (aresetn low, async):
  - w_ptr, r_ptr, in_pkt and count clear to 0; FSM goes to CLOSED.
  - s_axis_tready = 0 (combinationally forced while aresetn is low); m_axis_tvalid = 0; gated = 1.
  - The storage array is not reset.
- Pointers:
  - DEPTH_LOG2+1 bits each; wrap naturally.
  - Empty when w_ptr == r_ptr. Full when the MSBs differ and the low bits are equal.
  - Write on s handshake to mem[w_ptr low bits]; read on m handshake.
- s_axis_tready = aresetn && !full. There is no pass-through when full: a pop on a full cycle frees a slot the next cycle.
- Output data: m_axis_{tdata,tlast} = mem[r_ptr low bits], read combinationally.
- Latency: a beat accepted at edge k may appear on m_axis at cycle k+1 if the gate is OPEN.
- m_axis_tvalid = (state != CLOSED) && !empty.
- in_pkt:
  - Set on an m handshake with tlast = 0; cleared on an m handshake with tlast = 1.
  - Marks that the output is mid-packet.
- FSM states: CLOSED, OPEN, DRAIN. Transitions are registered and take effect the next cycle.
  - CLOSED -> OPEN: enable = 1. In PACKET_MODE this is always a boundary, because the gate only closes at boundaries.
  - OPEN, PACKET_MODE = 0:
    - -> CLOSED when enable = 0 and (!m_axis_tvalid || m handshake).
    - Never lowers tvalid without a handshake.
  - OPEN, PACKET_MODE = 1, enable = 0:
    - -> CLOSED if !in_pkt and !m_axis_tvalid.
    - -> CLOSED on an m handshake with tlast = 1.
    - Otherwise -> DRAIN.
  - DRAIN:
    - Output continues until an m handshake with tlast = 1, then -> CLOSED.
    - If enable returns to 1 first -> OPEN.
- The input side is never gated; the FIFO keeps filling while CLOSED until full.
- flush:
  - In CLOSED: r_ptr <= w_ptr and in_pkt <= 0; any s handshake that same cycle is discarded.
  - In OPEN or DRAIN: ignored.
- count: registered w_ptr - r_ptr, updated on the same edge as the pointers. Simultaneous push and pop leave count unchanged.
- gated = (state == CLOSED), registered.
- AXIS rules:
  - tvalid, once high, stays high with tdata and tlast stable until tready.
  - No combinational path from m_axis_tready to s_axis_tready.

Test Plan:
- Reset then enable = 1, push 0x11, 0x22, 0x33 (last on 0x33), m_tready = 1 -> outputs in order from cycle 1 after the first push; count returns to 0; tlast only on 0x33.
- enable = 0, push D beats -> s_tready drops after beat D; count = D; m_tvalid = 0; gated = 1. Then enable = 1 -> all D beats drain in order with wrap-around correct.
- PACKET_MODE = 1, 4-beat packet, enable drops after beat 2 handshake -> state DRAIN; beats 3-4 still delivered; gated = 1 the cycle after the tlast handshake; the next packet is held.
- PACKET_MODE = 0, same stimulus -> output stops after the current handshake with tvalid held high until that handshake; remaining beats are kept (count = 2).
- Full FIFO with enable = 0 and flush = 1 -> count = 0 next cycle, s_tready = 1; flush asserted while OPEN -> no effect.
- aresetn asserted mid-packet with count = 3 -> immediately m_tvalid = 0 and s_tready = 0; after release count = 0, gated = 1.
